// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes and SR/Cause field positions.
// Timer registers (Count/Compare) exist only when CP0_TIMER_EN is defined.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE_BIT     = 0;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IM_LSB     = 10;
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_BD_BIT  = 31;

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer with a pending flag that feeds interrupt line 5.
// Only instantiated when CP0_TIMER_EN is defined.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        we_i,
    input  logic [4:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        pend_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        pend_q, pend_d;

    always_comb begin
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        pend_d    = pend_q;
        if (count_q == compare_q && compare_q != 32'd0) pend_d = 1'b1;
        if (we_i && addr_i == CP0_COUNT) count_d = wdata_i;
        // Writing Compare acknowledges the timer interrupt, even if a match happens this cycle.
        if (we_i && addr_i == CP0_COMPARE) begin
            compare_d = wdata_i;
            pend_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            pend_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt responder for the M stage: SR/Cause/EPC, req and eret support.
// Define CP0_TIMER_EN to add the Count/Compare timer on interrupt line 5.
module cp0_exc_unit #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h0000_CAFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [31:0] vpc,
    input  logic        bd,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc,
    output logic [31:0] handler_pc
);
    import cp0_pkg::*;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;
    logic [5:0]  hw_eff;
    logic        int_req, exc_req;

`ifdef CP0_TIMER_EN
    logic [31:0] tmr_count, tmr_compare;
    logic        tmr_pend;

    // A taken exception drops any mtc0 in flight, timer writes included.
    cp0_timer u_timer (
        .clk_i     (clk),
        .reset_i   (reset),
        .we_i      (we & ~req),
        .addr_i    (addr),
        .wdata_i   (wdata),
        .count_o   (tmr_count),
        .compare_o (tmr_compare),
        .pend_o    (tmr_pend)
    );
    assign hw_eff = hw_int | {tmr_pend, 5'b0};
`else
    assign hw_eff = hw_int;
`endif

    assign int_req = (|(hw_eff & im_q)) & ie_q & ~exl_q;
    assign exc_req = (exc_code != EXC_INT) & ~exl_q;
    assign req     = int_req | exc_req;

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = hw_eff;
        exc_d = exc_q;
        epc_d = epc_q;
        if (req) begin
            exl_d = 1'b1;
            bd_d  = bd;
            exc_d = int_req ? EXC_INT : exc_code;
            epc_d = (vpc - (bd ? 32'd4 : 32'd0)) & 32'hFFFF_FFFC;
        end else begin
            if (we && addr == CP0_SR) begin
                im_d  = wdata[SR_IM_LSB +: 6];
                exl_d = wdata[SR_EXL_BIT];
                ie_d  = wdata[SR_IE_BIT];
            end
            if (we && addr == CP0_EPC) epc_d = wdata & 32'hFFFF_FFFC;
            // Evaluated last so eret's EXL clear beats a same-cycle SR write.
            if (eret) exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= 6'd0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= 6'd0;
            exc_q <= 5'd0;
            epc_q <= 32'd0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            CP0_SR:    rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
            CP0_CAUSE: rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};
            CP0_EPC:   rdata = epc_q;
            CP0_PRID:  rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
            CP0_COUNT:   rdata = tmr_count;
            CP0_COMPARE: rdata = tmr_compare;
`endif
            default:   rdata = 32'd0;
        endcase
    end

    assign epc        = epc_q;
    assign handler_pc = HANDLER_PC;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit: directed scenarios plus random traffic against a word-level CP0 model.
// Define CP0_TIMER_EN to also exercise the Count/Compare timer.
module tb_cp0_exc_unit;
  import cp0_pkg::*;

  logic        clk, reset, we, bd, eret, req;
  logic [4:0]  addr, exc_code;
  logic [5:0]  hw_int;
  logic [31:0] wdata, rdata, vpc, epc, handler_pc;

  int n_vec = 0;
  int n_bad = 0;

  // model state held as whole architectural register words
  logic [31:0] m_sr, m_cause, m_epc;
  logic [31:0] m_count, m_compare;
  logic        m_pend;

  cp0_exc_unit dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .vpc(vpc), .bd(bd), .exc_code(exc_code), .hw_int(hw_int), .eret(eret),
    .req(req), .epc(epc), .handler_pc(handler_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_hw();
`ifdef CP0_TIMER_EN
    return {26'd0, hw_int} | (m_pend ? 32'h20 : 32'h0);
`else
    return {26'd0, hw_int};
`endif
  endfunction

  function automatic bit m_int();
    logic [31:0] im = (m_sr >> 10) & 32'h3F;
    return ((m_hw() & im) != 0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_req();
    return m_int() || (exc_code != 0 && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_rdata();
    case (addr)
      5'd12: return m_sr;
      5'd13: return m_cause;
      5'd14: return m_epc;
      5'd15: return 32'h0000_CAFE;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_in(input bit w, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] pc, input bit b, input logic [4:0] ec,
                        input logic [5:0] hw, input bit er);
    we = w; addr = a; wdata = d; vpc = pc; bd = b; exc_code = ec; hw_int = hw; eret = er;
  endtask

  task automatic idle(input logic [4:0] a);
    set_in(0, a, 32'd0, 32'h0000_1000, 0, 5'd0, 6'd0, 0);
  endtask

  // compare outputs, clock once, advance the model using the pre-edge inputs
  task automatic tick();
    bit r, ri;
    logic [31:0] hwv, nxt_count;
    #1;
    r  = m_req();
    ri = m_int();
    hwv = m_hw();
    check_eq("req", req, r);
    check_eq("rdata", rdata, m_rdata());
    check_eq("epc", epc, m_epc);
    check_eq("handler_pc", handler_pc, 32'h0000_4180);
    @(posedge clk);
    if (r) begin
      m_sr    = m_sr | 32'h2;
      m_cause = (bd ? 32'h8000_0000 : 32'h0) | (hwv << 10) | ((ri ? 32'd0 : 32'(exc_code)) << 2);
      m_epc   = (bd ? vpc - 32'd4 : vpc) & ~32'd3;
    end else begin
      m_cause = (m_cause & ~(32'h3F << 10)) | (hwv << 10);
      if (we && addr == 5'd12) m_sr = wdata & 32'h0000_FC03;
      if (we && addr == 5'd14) m_epc = wdata & ~32'd3;
      if (eret) m_sr = m_sr & ~32'h2;
    end
    nxt_count = m_count + 1;
    if (m_count == m_compare && m_compare != 0) m_pend = 1'b1;
    if (!r && we && addr == 5'd9) nxt_count = wdata;
    if (!r && we && addr == 5'd11) begin
      m_compare = wdata;
      m_pend    = 1'b0;
    end
    m_count = nxt_count;
    @(negedge clk);
  endtask

  logic [4:0] addr_tab [7];
  logic [4:0] exc_tab  [4];
  bit seen;

  initial begin
    addr_tab = '{CP0_COUNT, CP0_COMPARE, CP0_SR, CP0_CAUSE, CP0_EPC, CP0_PRID, 5'd3};
    exc_tab  = '{EXC_ADEL, EXC_ADES, EXC_RI, EXC_OV};
    reset = 1'b1;
    idle(5'd12);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_sr = 0; m_cause = 0; m_epc = 0; m_count = 0; m_compare = 0; m_pend = 0;

    // reset state
    #1;
    check_eq("rst_req", req, 0);
    check_eq("rst_sr", rdata, 0);
    idle(5'd13); #1 check_eq("rst_cause", rdata, 0);
    idle(5'd14); #1 check_eq("rst_epc", rdata, 0);
    tick();

    // 1: interrupt on IP[12]
    set_in(1, CP0_SR, 32'h0000_FC01, 32'h0000_1000, 0, 5'd0, 6'd0, 0); tick();
    set_in(0, 5'd0, 32'd0, 32'h0000_2468, 0, 5'd0, 6'b000100, 0);
    #1 check_eq("t1_req", req, 1);
    tick();
    set_in(0, CP0_CAUSE, 32'd0, 32'h0, 0, 5'd0, 6'b000100, 0);
    #1 check_eq("t1_cause", rdata, 32'h0000_1000);
    check_eq("t1_epc", epc, 32'h0000_2468);
    addr = CP0_SR; #1 check_eq("t1_sr", rdata, 32'h0000_FC03);
    tick();

    // 2: overflow in a delay slot
    set_in(0, 5'd0, 32'd0, 32'h0, 0, 5'd0, 6'd0, 1); tick();
    set_in(0, 5'd0, 32'd0, 32'h0000_3010, 1, EXC_OV, 6'd0, 0);
    #1 check_eq("t2_req", req, 1);
    tick();
    idle(CP0_CAUSE);
    #1 check_eq("t2_cause", rdata, 32'h8000_0030);
    check_eq("t2_epc", epc, 32'h0000_300C);
    tick();

    // 3: EXL masks everything until eret
    set_in(0, 5'd0, 32'd0, 32'h0000_4000, 0, EXC_ADEL, 6'h3F, 0);
    #1 check_eq("t3_masked", req, 0);
    tick();
    set_in(0, 5'd0, 32'd0, 32'h0000_4004, 0, 5'd0, 6'h3F, 1); tick();
    set_in(0, 5'd0, 32'd0, 32'h0000_4008, 0, 5'd0, 6'h3F, 0);
    #1 check_eq("t3_after_eret", req, 1);
    tick();

    // 4: mtc0 EPC dropped by a same-cycle exception
    set_in(0, 5'd0, 32'd0, 32'h0, 0, 5'd0, 6'd0, 1); tick();
    set_in(1, CP0_EPC, 32'h1234_5678, 32'h0000_2000, 0, EXC_RI, 6'd0, 0);
    #1 check_eq("t4_req", req, 1);
    tick();
    idle(CP0_EPC);
    #1 check_eq("t4_epc_rd", rdata, 32'h0000_2000);
    tick();

    // 5: EPC alignment, PRId, unmapped address
    set_in(0, 5'd0, 32'd0, 32'h0, 0, 5'd0, 6'd0, 1); tick();
    set_in(1, CP0_EPC, 32'h0000_3007, 32'h0, 0, 5'd0, 6'd0, 0); tick();
    idle(CP0_PRID);
    #1 check_eq("t5_epc", epc, 32'h0000_3004);
    check_eq("t5_prid", rdata, 32'h0000_CAFE);
    addr = 5'd3; #1 check_eq("t5_unmapped", rdata, 0);
    tick();

`ifdef CP0_TIMER_EN
    // 6: timer interrupt through IM[15]
    set_in(1, CP0_SR, 32'h0000_8001, 32'h0, 0, 5'd0, 6'd0, 0); tick();
    set_in(1, CP0_COMPARE, 32'd5, 32'h0, 0, 5'd0, 6'd0, 0); tick();
    set_in(1, CP0_COUNT, 32'd0, 32'h0, 0, 5'd0, 6'd0, 0); tick();
    idle(CP0_COUNT);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1 if (req) seen = 1;
      tick();
    end
    check_eq("t6_timer_req", seen, 1);
    set_in(1, CP0_COMPARE, 32'd0, 32'h0, 0, 5'd0, 6'd0, 0); tick();
    set_in(0, 5'd0, 32'd0, 32'h0, 0, 5'd0, 6'd0, 1); tick();
    idle(CP0_CAUSE);
    #1 check_eq("t6_req_drop", req, 0);
    tick();
`endif

    // random traffic
    for (int n = 0; n < 600; n++) begin
      set_in($urandom_range(0, 3) == 0,
             ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : addr_tab[$urandom_range(0, 6)],
             ($urandom_range(0, 1) == 0) ? $urandom : (32'h0000_FC01 & $urandom),
             $urandom, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0) ? exc_tab[$urandom_range(0, 3)] : 5'd0,
             ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0,
             $urandom_range(0, 7) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt responder sitting beside the M stage of the five-stage MIPS pipeline.
- Consumes the M-stage PC, branch-delay flag, pending exception code and external hardware interrupt lines.
- Decides whether to take an exception, producing the one-bit `req` that flushes all pipeline registers and redirects fetch to 0x00004180.
- Holds SR/Cause/EPC for mtc0/mfc0 and provides EPC for eret.

Parameters:
- HANDLER_PC, 32'h00004180, exception entry address driven on handler_pc.
- PRID_VAL, 32'h0000_CAFE, constant returned for CP0 register 15.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- we  input  1  mtc0 write strobe from M stage.
- addr  input  5  CP0 register number for mtc0/mfc0.
- wdata  input  32  mtc0 write data.
- rdata  output  32  mfc0 read data, combinational.
- vpc  input  32  PC of the instruction currently in M.
- bd  input  1  M instruction is in a branch delay slot.
- exc_code  input  5  pending exception code for the M instruction; 0 = none.
- hw_int  input  6  external interrupt lines, level-sensitive.
- eret  input  1  eret in M stage.
- req  output  1  take exception this cycle, combinational.
- epc  output  32  current EPC register value.
- handler_pc  output  32  constant HANDLER_PC.

Behaviour:

Registers:
- SR (addr 12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause (addr 13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
- EPC (addr 14): 32-bit, bits [1:0] forced to 0.

Reset:
- SR, Cause and EPC are cleared to 0.
- With hw_int=0 and exc_code=0, req=0 and rdata reflects the zeroed registers.

Request logic (combinational):
- int_req = |(hw_int & IM) & IE & ~EXL.
- exc_req = (exc_code != 0) & ~EXL.
- req = int_req | exc_req.

Priority:
- An interrupt beats a synchronous exception in the same cycle.
- On an interrupt, the recorded ExcCode is 0.

Clock edge with req=1:
- EXL <= 1.
- BD <= bd.
- ExcCode <= int_req ? 0 : exc_code.
- EPC <= bd ? (vpc - 4) & ~3 : vpc & ~3.
- Any simultaneous mtc0 or eret is dropped.

IP update:
- IP[15:10] <= hw_int on every non-reset edge, regardless of req.
- IP is never software-writable.

mtc0 (we=1, req=0):
- addr 12 writes IM, EXL, IE; other SR bits are ignored.
- addr 14 writes EPC with bits [1:0] cleared.
- addr 13, addr 15 and all other addresses are ignored.
- A write becomes visible on rdata the following cycle; there is no internal bypass.

eret (eret=1, req=0):
- EXL <= 0 at the edge.
- If eret and an mtc0 to SR occur in the same cycle, eret's EXL clear wins and the IM/IE fields still take wdata.

mfc0:
- rdata = register selected by addr (12/13/14).
- addr 15 returns PRID_VAL; all other addresses return 0.

EXL semantics:
- While EXL=1, no new interrupt or exception is taken.
- exc_code on a flushed bubble is expected to be 0; the unit does not filter it.

Latency:
- req is same-cycle.
- State updates take effect at the next edge.
- epc reflects the new value one cycle after the exception.

Optional Feature:
- Macro: CP0_TIMER_EN.
- When defined:
  - Adds Count (addr 9) and Compare (addr 11). Count increments by 1 every cycle and wraps at 2^32.
  - mtc0 can write both Count and Compare. A Count write overrides that cycle's increment.
  - A timer-pending flag sets when Count == Compare and Compare != 0, and clears on any mtc0 to Compare.
  - The flag is ORed into the hw_int[5] input before IP capture and masking.
- When undefined:
  - Addr 9 and addr 11 read 0 and ignore writes.
  - No timer logic is present.

Decomposition:
- Package cp0_pkg:
  - Register address constants: CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15, CP0_COUNT=9, CP0_COMPARE=11.
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12.
  - SR/Cause bit-position constants.
- One optional sub-module, cp0_timer, containing Count, Compare and the pending flag; instantiated only under CP0_TIMER_EN.

Test Plan:
1. Reset, then mtc0 SR=0x0000FC01 and hw_int=6'b000100 → req=1 the next cycle; at the edge EXL=1, Cause=0x00001000 (IP[12] set, ExcCode 0), EPC=vpc.
2. exc_code=12 (Ov), vpc=0x00003010, bd=1, EXL=0 → req=1; at the edge EPC=0x0000300C, Cause[31]=1, ExcCode=12.
3. With EXL=1, exc_code=4 and hw_int=6'h3F → req stays 0; eret → EXL=0 the next cycle, after which req=1 for the interrupt.
4. Same cycle: we=1, addr=14, wdata=0x12345678, plus exc_code=10 → req=1; EPC=vpc (write dropped); rdata at addr 14 does not show 0x12345678.
5. mtc0 EPC=0x00003007 → epc=0x00003004; mfc0 addr 15 → rdata=PRID_VAL; mfc0 addr 3 → rdata=0.
6. (CP0_TIMER_EN) Compare=5, Count=0, SR IM[15]=1, IE=1 → req asserts when Count==5; mtc0 Compare clears the pending flag and req drops.
